// File: rtl/data_memory_ctrl_if.sv
// Request/acknowledge bus between the MEM stage and the data memory controller.
// Signal names carry the controller-side direction.
interface data_memory_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] data_o;
    logic        err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, data_i,
        input  ready_o, ack_o, data_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, data_i,
        output ready_o, ack_o, data_o, err_o
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with req/ack handshake, fixed access latency,
// sub-word loads/stores with sign/zero extension and misalign/size/range error reporting.
module data_memory_ctrl #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    data_memory_ctrl_if.slave  bus
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, uns_q;
    logic [1:0]      size_q;
    logic [31:0]     addr_q, wdata_q;
    logic            ack_q, ack_d, err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [7:0]      mem_q [DEPTH];

    logic            accept, wr_en, bad;
    logic [2:0]      nbytes;
    logic [3:0]      lane_en;
    logic [32:0]     last_byte;
    logic [AddrW-1:0] lane_addr [4];
    logic [31:0]     raw, load_val;

    // Decode of the registered request; valid throughout BUSY.
    always_comb begin
        nbytes  = 3'd4;
        lane_en = 4'b1111;
        unique case (size_q)
            2'b00: begin nbytes = 3'd1; lane_en = 4'b0001; end
            2'b01: begin nbytes = 3'd2; lane_en = 4'b0011; end
            default: ;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        last_byte = {1'b0, addr_q} + {30'd0, nbytes} - 33'd1;
        bad = (size_q == 2'b11)
            | ((size_q == 2'b01) & addr_q[0])
            | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
            | (last_byte >= 33'(DEPTH));
        raw = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            lane_addr[k]  = addr_q[AddrW-1:0] + AddrW'(k);
            raw[8*k +: 8] = mem_q[lane_addr[k]];
        end
        unique case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   load_val = uns_q ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: load_val = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        accept  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_i) begin
                    accept  = 1'b1;
                    state_d = StBusy;
                    cnt_d   = CntW'(LATENCY - 1);
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    ack_d   = 1'b1;
                    err_d   = bad;
                    if (!bad) begin
                        if (we_q) wr_en   = 1'b1;
                        else      rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= bus.we_i;
                uns_q   <= bus.unsigned_i;
                size_q  <= bus.size_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (lane_en[k]) mem_q[lane_addr[k]] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign bus.ready_o = (state_q == StIdle);
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.data_o  = rdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench: directed plan plus random accesses on a default build and a
// LATENCY=1/DEPTH=32 build, checked against a byte-array reference model.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_memory_ctrl_if bus_a();
    data_memory_ctrl_if bus_b();

    data_memory_ctrl #(.DEPTH(1024), .LATENCY(2)) dut_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a)
    );

    data_memory_ctrl #(.DEPTH(32), .LATENCY(1)) dut_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [7:0]  mem_a [1024];
    logic [7:0]  mem_b [32];
    logic [31:0] exp_do_a, exp_do_b;
    logic        last_err;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rd_ack(input bit sel);
        return sel ? bus_b.ack_o : bus_a.ack_o;
    endfunction
    function automatic logic rd_ready(input bit sel);
        return sel ? bus_b.ready_o : bus_a.ready_o;
    endfunction
    function automatic logic rd_err(input bit sel);
        return sel ? bus_b.err_o : bus_a.err_o;
    endfunction
    function automatic logic [31:0] rd_data(input bit sel);
        return sel ? bus_b.data_o : bus_a.data_o;
    endfunction

    task automatic drive(input bit sel, input bit req, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] data);
        if (sel) begin
            bus_b.req_i = req; bus_b.we_i = we; bus_b.size_i = size;
            bus_b.unsigned_i = uns; bus_b.addr_i = addr; bus_b.data_i = data;
        end else begin
            bus_a.req_i = req; bus_a.we_i = we; bus_a.size_i = size;
            bus_a.unsigned_i = uns; bus_a.addr_i = addr; bus_a.data_i = data;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) mem_a[i] = 8'h00;
        for (int i = 0; i < 32; i++) mem_b[i] = 8'h00;
        exp_do_a = '0;
        exp_do_b = '0;
    endtask

    // Reference: applies one access to the byte arrays and returns the expected error.
    task automatic model_access(input bit sel, input bit we, input logic [1:0] size,
                                input bit uns, input logic [31:0] addr,
                                input logic [31:0] data, output bit err);
        longint      depth;
        int          nb;
        logic [31:0] val;
        depth = sel ? 32 : 1024;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        err = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
              (size == 2'b10 && addr % 4 != 0) || ({32'd0, addr} + nb - 1 >= depth);
        if (!err) begin
            if (we) begin
                for (int k = 0; k < nb; k++) begin
                    if (sel) mem_b[addr + k] = data[8*k +: 8];
                    else     mem_a[addr + k] = data[8*k +: 8];
                end
            end else begin
                val = '0;
                for (int k = 0; k < nb; k++)
                    val[8*k +: 8] = sel ? mem_b[addr + k] : mem_a[addr + k];
                if (!uns && nb == 1 && val[7])  val = val | 32'hFFFF_FF00;
                if (!uns && nb == 2 && val[15]) val = val | 32'hFFFF_0000;
                if (sel) exp_do_b = val;
                else     exp_do_a = val;
            end
        end
    endtask

    // Waits (bounded) for ack at negedges; n = posedges after acceptance when it arrived.
    task automatic wait_ack(input bit sel, output int n, output bit timeout);
        n = 0;
        timeout = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_ack(sel)) break;
            if (n >= 16) begin timeout = 1'b1; break; end
            if (sel) bus_b.addr_i = $urandom; else bus_a.addr_i = $urandom;
            n++;
        end
    endtask

    task automatic access(input bit sel, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] data);
        int n;
        bit timeout, exp_err;
        @(negedge clk);
        check("ready_idle", rd_ready(sel), 1'b1);
        drive(sel, 1'b1, we, size, uns, addr, data);
        @(posedge clk);
        model_access(sel, we, size, uns, addr, data, exp_err);
        #1;
        // Scramble everything while busy; the captured request must be used.
        drive(sel, 1'b0, $urandom, $urandom, $urandom, $urandom, $urandom);
        check("ready_busy", rd_ready(sel), 1'b0);
        wait_ack(sel, n, timeout);
        if (timeout) begin
            check("ack_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(n), sel ? 32'd1 : 32'd2);
            check("err", rd_err(sel), exp_err);
            check("data", rd_data(sel), sel ? exp_do_b : exp_do_a);
            check("ready_ack", rd_ready(sel), 1'b1);
            last_err = rd_err(sel);
            @(negedge clk);
            check("ack_pulse", rd_ack(sel), 1'b0);
        end
    endtask

    task automatic back_to_back();
        logic [31:0] addrs [3];
        int          ack_cyc [3];
        int          n;
        bit          timeout, exp_err;
        addrs[0] = 32'h20; addrs[1] = 32'h24; addrs[2] = 32'h10;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, addrs[0], 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            model_access(0, 1'b0, 2'b10, 1'b0, addrs[i], 32'h0, exp_err);
            wait_ack(0, n, timeout);
            ack_cyc[i] = cyc;
            if (timeout) check("b2b_timeout", 32'd0, 32'd1);
            check("b2b_data", bus_a.data_o, exp_do_a);
            if (i < 2) bus_a.addr_i = addrs[i + 1];
            else       bus_a.req_i = 1'b0;
        end
        check("b2b_gap0", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        check("b2b_gap1", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
        @(negedge clk);
        check("b2b_end", bus_a.ack_o, 1'b0);
    endtask

    initial begin
        bit   got_ack, sel, we, uns;
        logic [1:0]  size;
        logic [31:0] addr;
        int   depth, r;

        rst_n = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready_a", bus_a.ready_o, 1'b1);
        check("rst_ack_a", bus_a.ack_o, 1'b0);
        check("rst_data_a", bus_a.data_o, 32'h0);
        check("rst_ready_b", bus_b.ready_o, 1'b1);
        rst_n = 1'b1;

        access(0, 1, 2'b10, 0, 32'h20, 32'h1234_5678);
        access(0, 0, 2'b10, 0, 32'h20, 32'h0);
        check("plan_word", bus_a.data_o, 32'h1234_5678);

        // Reset in the middle of a store.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk);
        @(negedge clk);
        bus_a.req_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", bus_a.ready_o, 1'b1);
        check("midrst_ack", bus_a.ack_o, 1'b0);
        check("midrst_data", bus_a.data_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        got_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            got_ack = got_ack | bus_a.ack_o;
        end
        check("midrst_noack", got_ack, 1'b0);
        access(0, 0, 2'b10, 0, 32'h10, 32'h0);
        check("plan_rst_load", bus_a.data_o, 32'h0);
        access(0, 0, 2'b10, 0, 32'h20, 32'h0);
        check("plan_rst_clear", bus_a.data_o, 32'h0);

        // Sub-word accesses.
        access(0, 1, 2'b10, 0, 32'h20, 32'h1234_5678);
        access(0, 1, 2'b00, 0, 32'h21, 32'h0000_0080);
        access(0, 0, 2'b10, 0, 32'h20, 32'h0);
        check("plan_merge", bus_a.data_o, 32'h1234_8078);
        access(0, 0, 2'b00, 0, 32'h21, 32'h0);
        check("plan_lb", bus_a.data_o, 32'hFFFF_FF80);
        access(0, 0, 2'b00, 1, 32'h21, 32'h0);
        check("plan_lbu", bus_a.data_o, 32'h0000_0080);
        access(0, 0, 2'b01, 0, 32'h22, 32'h0);
        check("plan_lh", bus_a.data_o, 32'h0000_1234);

        // Error cases.
        access(0, 0, 2'b10, 0, 32'h22, 32'h0);
        check("plan_err_mis_word", last_err, 1'b1);
        check("plan_err_hold", bus_a.data_o, 32'h0000_1234);
        access(0, 1, 2'b01, 0, 32'h23, 32'hFFFF);
        check("plan_err_mis_half", last_err, 1'b1);
        access(0, 0, 2'b10, 0, 32'h20, 32'h0);
        check("plan_err_nowrite", bus_a.data_o, 32'h1234_8078);
        access(0, 0, 2'b11, 0, 32'h20, 32'h0);
        check("plan_err_size", last_err, 1'b1);
        access(0, 0, 2'b10, 0, 32'd1022, 32'h0);
        check("plan_err_range", last_err, 1'b1);
        access(0, 1, 2'b10, 0, 32'hFFFF_FFFC, 32'h5555_5555);
        check("plan_err_nowrap", last_err, 1'b1);
        access(0, 1, 2'b00, 0, 32'd1023, 32'h0000_00A5);
        access(0, 0, 2'b00, 1, 32'd1023, 32'h0);
        check("plan_top_byte", bus_a.data_o, 32'h0000_00A5);
        access(0, 0, 2'b10, 0, 32'h0, 32'h0);
        check("plan_nowrap_low", bus_a.data_o, 32'h0);

        back_to_back();

        // Small fast build.
        access(1, 1, 2'b10, 0, 32'h1C, 32'hCAFE_F00D);
        access(1, 0, 2'b10, 0, 32'h1C, 32'h0);
        check("plan_b_word", bus_b.data_o, 32'hCAFE_F00D);
        access(1, 0, 2'b10, 0, 32'h20, 32'h0);
        check("plan_b_range", last_err, 1'b1);

        for (int i = 0; i < 300; i++) begin
            sel   = $urandom_range(0, 1);
            we    = $urandom_range(0, 1);
            uns   = $urandom_range(0, 1);
            size  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            depth = sel ? 32 : 1024;
            r     = $urandom_range(0, 15);
            if (r == 0)      addr = $urandom;
            else if (r < 4)  addr = $urandom_range(depth - 6, depth + 3);
            else             addr = $urandom_range(0, depth - 1);
            if (r >= 6 && size == 2'b01) addr[0] = 1'b0;
            if (r >= 6 && size == 2'b10) addr[1:0] = 2'b00;
            access(sel, we, size, uns, addr, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
